conv_fprop_sdiv_32s_32s_32_seq_1: RTL

- Multi-cycle sequential signed integer divider for the conv_fprop datapath.
- Inverse arithmetic companion to the pipelined signed multiplier; used for normalisation and index recovery (divide and modulo by stride or channel count).
- Radix-2 restoring division on magnitudes, then a sign-fix cycle.
- start/done handshake; ce stalls the whole block, as for the other arithmetic cores.

---
 rtl/conv_fprop_div_pkg.sv | 25 ++
 rtl/conv_fprop_udiv_step.sv | 28 ++
 rtl/conv_fprop_sdiv_32s_32s_32_seq_1.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/conv_fprop_div_pkg.sv
// Shared types and constants for the conv_fprop sequential divider.
package conv_fprop_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  localparam int DIV_W    = 32;
  localparam int DIV_ITER = 32;
  localparam int CNT_W    = 5;

  // Magnitude as unsigned; 0x80000000 maps to 2^31 without saturation.
  function automatic logic [DIV_W-1:0] div_abs(input logic [DIV_W-1:0] v);
    logic [DIV_W-1:0] r;
    if (v[DIV_W-1]) begin
      r = ~v + {{(DIV_W-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/conv_fprop_udiv_step.sv
// One combinational radix-2 restoring division step on unsigned magnitudes.
module conv_fprop_udiv_step
  import conv_fprop_div_pkg::*;
(
  input  logic [DIV_W:0]   prem,
  input  logic             dbit,
  input  logic [DIV_W-1:0] dvs,
  output logic [DIV_W:0]   prem_nxt,
  output logic             qbit
);

  logic [DIV_W+1:0] shift_s;
  logic [DIV_W+1:0] diff_s;

  // Shift in the next dividend bit and trial-subtract the divisor
  always_comb begin
    shift_s = {prem, dbit};
    diff_s  = shift_s - {2'b00, dvs};
    if (!diff_s[DIV_W+1]) begin
      qbit     = 1'b1;
      prem_nxt = diff_s[DIV_W:0];
    end else begin
      qbit     = 1'b0;
      prem_nxt = shift_s[DIV_W:0];
    end
  end

endmodule

// File: rtl/conv_fprop_sdiv_32s_32s_32_seq_1.sv
// Multi-cycle signed divider: 32 restoring steps on magnitudes, then a sign-fix cycle.
module conv_fprop_sdiv_32s_32s_32_seq_1
  import conv_fprop_div_pkg::*;
#(
  parameter int din0_WIDTH = 32,
  parameter int din1_WIDTH = 32,
  parameter int dout_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  busy,
  output logic                  done,
  output logic [dout_WIDTH-1:0] quot,
  output logic [dout_WIDTH-1:0] rem
);

  div_state_e       state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [DIV_W-1:0] dvd_r, dvs_r;
  logic [DIV_W:0]   prem_r;
  logic             sign_q_r, sign_r_r, div0_r;
  logic             busy_r, done_r;
  logic [DIV_W-1:0] quot_r, rem_r;
  logic             accept_s, step_s, fix_s;
  logic [DIV_W:0]   prem_nxt_s;
  logic             qbit_s;
  logic [DIV_W-1:0] q_fix_s, r_fix_s;

  conv_fprop_udiv_step u_step (
    .prem     (prem_r),
    .dbit     (dvd_r[DIV_W-1]),
    .dvs      (dvs_r),
    .prem_nxt (prem_nxt_s),
    .qbit     (qbit_s)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else if (ce) begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = CALC;
        else       state_nxt_s = IDLE;
      end
      CALC: begin
        if (cnt_r == CNT_W'(DIV_ITER - 1)) state_nxt_s = FIX;
        else                               state_nxt_s = CALC;
      end
      FIX:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Per-state control strobes
  always_comb begin
    accept_s = 1'b0;
    step_s   = 1'b0;
    fix_s    = 1'b0;
    case (state_r)
      IDLE:    accept_s = start;
      CALC:    step_s   = 1'b1;
      FIX:     fix_s    = 1'b1;
      default: begin
        accept_s = 1'b0;
        step_s   = 1'b0;
        fix_s    = 1'b0;
      end
    endcase
  end

  // Operand capture and iteration datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r    <= {CNT_W{1'b0}};
      dvd_r    <= {DIV_W{1'b0}};
      dvs_r    <= {DIV_W{1'b0}};
      prem_r   <= {(DIV_W+1){1'b0}};
      sign_q_r <= 1'b0;
      sign_r_r <= 1'b0;
      div0_r   <= 1'b0;
    end else if (ce) begin
      if (accept_s) begin
        dvd_r    <= div_abs(din0);
        dvs_r    <= div_abs(din1);
        prem_r   <= {(DIV_W+1){1'b0}};
        cnt_r    <= {CNT_W{1'b0}};
        sign_q_r <= din0[DIV_W-1] ^ din1[DIV_W-1];
        sign_r_r <= din0[DIV_W-1];
        div0_r   <= (din1 == {din1_WIDTH{1'b0}});
      end else if (step_s) begin
        prem_r <= prem_nxt_s;
        dvd_r  <= {dvd_r[DIV_W-2:0], qbit_s};
        cnt_r  <= cnt_r + CNT_W'(1);
      end
    end
  end

  // Sign correction; a zero divisor forces an all-ones quotient, remainder keeps the dividend
  always_comb begin
    q_fix_s = dvd_r;
    r_fix_s = prem_r[DIV_W-1:0];
    if (div0_r) begin
      q_fix_s = {DIV_W{1'b1}};
    end else if (sign_q_r) begin
      q_fix_s = ~dvd_r + {{(DIV_W-1){1'b0}}, 1'b1};
    end else begin
      q_fix_s = dvd_r;
    end
    if (sign_r_r) begin
      r_fix_s = ~prem_r[DIV_W-1:0] + {{(DIV_W-1){1'b0}}, 1'b1};
    end else begin
      r_fix_s = prem_r[DIV_W-1:0];
    end
  end

  // Registered handshake and result outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      quot_r <= {DIV_W{1'b0}};
      rem_r  <= {DIV_W{1'b0}};
    end else if (ce) begin
      done_r <= fix_s;
      if (accept_s) begin
        busy_r <= 1'b1;
      end else if (fix_s) begin
        busy_r <= 1'b0;
      end
      if (fix_s) begin
        quot_r <= q_fix_s;
        rem_r  <= r_fix_s;
      end
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign quot = quot_r;
  assign rem  = rem_r;

endmodule
